// File: rtl/player_pkg.sv
// Shared definitions for the memory-game player checker and the game controller.
package player_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitPress,
    StRelease,
    StPass,
    StFail
  } state_e;

  localparam logic [1:0] FAIL_WRONG   = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
  localparam logic [1:0] FAIL_MULTI   = 2'd2;
  localparam logic [1:0] FAIL_BADLEN  = 2'd3;

  localparam int unsigned DEF_NUM_TILES = 4;
  localparam int unsigned DEF_MAX_LEN   = 9;
  localparam int unsigned DEF_TIMEOUT   = 50_000_000;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational key encoder: index of the pressed key plus any/multi flags.
module onehot_encoder #(
  parameter int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] keys,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (keys[i]) idx = W'(i);
    end
  end

  assign any   = |keys;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(keys & (keys - N'(1)));

endmodule

// File: rtl/player_checker.sv
// Checks one round of player key presses against a latched colour sequence.
module player_checker
  import player_pkg::*;
#(
  parameter int unsigned NUM_TILES = DEF_NUM_TILES,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  localparam int unsigned TILE_W   = $clog2(NUM_TILES),
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1),
  localparam int unsigned CNT_W    = $clog2(TIMEOUT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [LEN_W-1:0]          round_len,
  input  logic [MAX_LEN*TILE_W-1:0] seq,
  input  logic [NUM_TILES-1:0]      keys,
  output logic                      busy,
  output logic [LEN_W-1:0]          step,
  output logic [TILE_W-1:0]         tile_out,
  output logic                      tile_valid,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                fail_code
);

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          step_q, step_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MAX_LEN*TILE_W-1:0] seq_q, seq_d;
  logic [TILE_W-1:0]         tile_q, tile_d;
  logic [1:0]                code_q, code_d;
  logic                      tv_d;
  logic                      busy_q, tv_q, pass_q, fail_q;

  logic [TILE_W-1:0] key_idx;
  logic              key_any, key_multi;
  logic [TILE_W-1:0] exp_tile;

  onehot_encoder #(
    .N(NUM_TILES)
  ) u_enc (
    .keys (keys),
    .idx  (key_idx),
    .any  (key_any),
    .multi(key_multi)
  );

  assign exp_tile = seq_q[step_q*TILE_W +: TILE_W];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    tile_d  = tile_q;
    code_d  = code_q;
    tv_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (round_len == '0 || round_len > LEN_W'(MAX_LEN)) begin
            code_d  = FAIL_BADLEN;
            state_d = StFail;
          end else begin
            seq_d   = seq;
            len_d   = round_len;
            step_d  = '0;
            cnt_d   = '0;
            code_d  = FAIL_WRONG;
            state_d = StArm;
          end
        end
      end
      // A key still held from the previous round must be released first.
      StArm: begin
        if (!key_any) state_d = StWaitPress;
      end
      StWaitPress: begin
        cnt_d = cnt_q + 1'b1;
        if (key_multi) begin
          code_d  = FAIL_MULTI;
          state_d = StFail;
        end else if (key_any) begin
          tile_d = key_idx;
          tv_d   = 1'b1;
          if (key_idx == exp_tile) begin
            state_d = StRelease;
          end else begin
            code_d  = FAIL_WRONG;
            state_d = StFail;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          code_d  = FAIL_TIMEOUT;
          state_d = StFail;
        end
      end
      StRelease: begin
        if (!key_any) begin
          if (step_q == len_q - 1'b1) begin
            state_d = StPass;
          end else begin
            step_d  = step_q + 1'b1;
            cnt_d   = '0;
            state_d = StWaitPress;
          end
        end
      end
      StPass:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      tile_q  <= '0;
      code_q  <= FAIL_WRONG;
      busy_q  <= 1'b0;
      tv_q    <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      tile_q  <= tile_d;
      code_q  <= code_d;
      busy_q  <= (state_d != StIdle);
      tv_q    <= tv_d;
      pass_q  <= (state_d == StPass);
      fail_q  <= (state_d == StFail);
    end
  end

  assign busy       = busy_q;
  assign step       = step_q;
  assign tile_out   = tile_q;
  assign tile_valid = tv_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_code  = code_q;

endmodule

// File: tb/tb_player_checker.sv
// Randomised round-level bench for player_checker with a press/release reference model.
module tb_player_checker;

  localparam int unsigned NT = 4;
  localparam int unsigned ML = 9;
  localparam int unsigned TO = 16;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [3:0]  round_len;
  logic [17:0] seq;
  logic [3:0]  keys;
  logic        busy;
  logic [3:0]  step;
  logic [1:0]  tile_out;
  logic        tile_valid;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;

  int n_checks = 0;
  int n_fail   = 0;
  int tiles[ML];

  player_checker #(
    .NUM_TILES(NT),
    .MAX_LEN  (ML),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .round_len (round_len),
    .seq       (seq),
    .keys      (keys),
    .busy      (busy),
    .step      (step),
    .tile_out  (tile_out),
    .tile_valid(tile_valid),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step"}, step, 0);
    check({tag, "_tile_out"}, tile_out, 0);
    check({tag, "_tile_valid"}, tile_valid, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_fail_code"}, fail_code, 0);
  endtask

  task automatic start_round(input int len, input int hold_tile, input int hold);
    logic [17:0] p;
    p = '0;
    for (int i = 0; i < ML; i++) p[i*2 +: 2] = 2'(tiles[i]);
    keys = (hold > 0) ? (4'b0001 << hold_tile) : 4'b0000;
    start = 1'b1;
    round_len = 4'(len);
    seq = p;
    tick();
    start = 1'b0;
    // Later changes to the sequence inputs must not matter.
    seq = 18'($urandom);
    round_len = 4'($urandom);
    check("busy_after_start", busy, 1);
    check("step_after_start", step, 0);
    check("code_after_start", fail_code, 0);
    for (int j = 0; j < hold; j++) begin
      tick();
      check("held_key_ignored", tile_valid, 0);
    end
    keys = 4'b0000;
    tick();
  endtask

  // fault_kind: 0 none, 1 wrong tile, 2 multi-key, 3 timeout (at fault_step)
  task automatic play_round(input int len, input int fault_step, input int fault_kind,
                            input int max_delay, output logic [1:0] exp_code);
    int d, w, a, b;
    exp_code = 2'd0;
    for (int s = 0; s < len; s++) begin
      if (s == fault_step && fault_kind == 3) begin
        for (int c = 1; c <= TO; c++) begin
          tick();
          if (c < TO) check("timeout_not_yet", fail, 0);
        end
        check("timeout_fail", fail, 1);
        check("timeout_code", fail_code, 1);
        check("timeout_step", step, s);
        exp_code = 2'd1;
        tick();
        check("timeout_busy_drop", busy, 0);
        return;
      end
      d = $urandom_range(0, max_delay);
      for (int c = 0; c < d; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
          round_len = 4'd0;
        end
        tick();
        start = 1'b0;
        check("idle_no_tv", tile_valid, 0);
        check("idle_no_fail", fail, 0);
      end
      if (s == fault_step && fault_kind == 2) begin
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        keys = (4'b0001 << a) | (4'b0001 << b);
        tick();
        keys = 4'b0000;
        check("multi_fail", fail, 1);
        check("multi_no_tv", tile_valid, 0);
        check("multi_code", fail_code, 2);
        exp_code = 2'd2;
        tick();
        check("multi_busy_drop", busy, 0);
        return;
      end
      if (s == fault_step && fault_kind == 1) begin
        w = (tiles[s] + $urandom_range(1, 3)) % 4;
        keys = 4'b0001 << w;
        tick();
        keys = 4'b0000;
        check("wrong_tv", tile_valid, 1);
        check("wrong_tile_out", tile_out, w);
        check("wrong_fail", fail, 1);
        check("wrong_code", fail_code, 0);
        check("wrong_step", step, s);
        exp_code = 2'd0;
        tick();
        check("wrong_busy_drop", busy, 0);
        return;
      end
      keys = 4'b0001 << tiles[s];
      tick();
      check("press_tv", tile_valid, 1);
      check("press_tile_out", tile_out, tiles[s]);
      check("press_no_fail", fail, 0);
      check("press_step", step, s);
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        if ($urandom_range(0, 1) == 1) keys = keys | (4'b0001 << $urandom_range(0, 3));
        tick();
        check("held_no_tv", tile_valid, 0);
        check("held_no_fail", fail, 0);
      end
      keys = 4'b0000;
      tick();
      if (s == len - 1) begin
        check("pass_pulse", pass, 1);
        check("pass_busy", busy, 1);
        check("pass_code", fail_code, 0);
        tick();
        check("pass_one_cycle", pass, 0);
        check("pass_busy_drop", busy, 0);
      end else begin
        check("step_advance", step, s + 1);
        check("no_early_pass", pass, 0);
      end
    end
  endtask

  task automatic bad_len(input int len);
    start = 1'b1;
    round_len = 4'(len);
    tick();
    start = 1'b0;
    check("badlen_fail", fail, 1);
    check("badlen_code", fail_code, 3);
    check("badlen_no_tv", tile_valid, 0);
    tick();
    check("badlen_busy_drop", busy, 0);
    check("badlen_one_cycle", fail, 0);
    check("badlen_code_held", fail_code, 3);
  endtask

  initial begin
    logic [1:0] ec;
    int len, fk, fs;
    resetn = 1'b1;
    start = 1'b0;
    round_len = '0;
    seq = '0;
    keys = '0;
    #3 resetn = 1'b0;
    #3 check_all_zero("reset");
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Correct round {2,0,3}
    tiles = '{2, 0, 3, 1, 1, 1, 1, 1, 1};
    start_round(3, 0, 0);
    play_round(3, -1, 0, 4, ec);
    // Wrong tile at step 0 (any non-matching tile)
    start_round(3, 0, 0);
    play_round(3, 0, 1, 4, ec);
    // Timeout at step 0, then a press at the last legal cycle
    start_round(3, 0, 0);
    play_round(3, 0, 3, 0, ec);
    repeat (3) tick();
    check("code_held_idle", fail_code, 1);
    start_round(1, 0, 0);
    for (int c = 0; c < TO - 1; c++) tick();
    keys = 4'b0100;
    tick();
    keys = 4'b0000;
    check("late_press_tv", tile_valid, 1);
    check("late_press_no_fail", fail, 0);
    tick();
    check("late_press_pass", pass, 1);
    tick();
    // Multi-key
    start_round(3, 0, 0);
    play_round(3, 0, 2, 3, ec);
    // Key held across start
    start_round(3, 1, 4);
    play_round(3, -1, 0, 3, ec);
    bad_len(0);
    bad_len(10);

    // Reset mid-round at step 1
    tiles = '{1, 3, 2, 0, 0, 0, 0, 0, 0};
    start_round(3, 0, 0);
    keys = 4'b0010;
    tick();
    keys = 4'b0000;
    tick();
    check("pre_reset_step", step, 1);
    keys = 4'b1000;
    tick();
    check("pre_reset_tv", tile_valid, 1);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    keys = 4'b0000;
    tick();
    check_all_zero("reset_held");
    resetn = 1'b1;
    tick();
    check("post_reset_no_pass", pass, 0);
    start_round(3, 0, 0);
    play_round(3, -1, 0, 3, ec);

    // Randomised rounds
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, ML);
      for (int i = 0; i < ML; i++) tiles[i] = $urandom_range(0, 3);
      fk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      fs = $urandom_range(0, len - 1);
      if ($urandom_range(0, 7) == 0) begin
        bad_len($urandom_range(0, 1) == 0 ? 0 : $urandom_range(ML + 1, 15));
      end else begin
        start_round(len, $urandom_range(0, 3), $urandom_range(0, 2));
        play_round(len, fs, fk, TO - 1, ec);
        tick();
        check("rand_idle_busy", busy, 0);
        check("rand_code_held", fail_code, ec);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
